// File: rtl/div_share_ctrl_pkg.sv
// div_ctrl_pkg: states, data-format constants and flag positions for the shared divider controller
package div_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int SIGN_BIT = 15;
  localparam int MAG_W = 15;
  localparam int FRAC_BITS = 8;
  localparam logic [MAG_W-1:0] DBZ_MAG = 15'h7FFF;
  localparam int FLG_COUT = 0;
  localparam int FLG_ZERO = 1;
  localparam int FLG_NEG = 2;
  localparam int FLG_OVF = 3;
  localparam int FLG_DBZ = 4;
  localparam int FLG_W = 5;
endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin pick of one requester, searching upward from ptr+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
  // Scan farthest-first so the nearest requester after ptr wins last
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        grant = NREQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one multicycle Q7.8 sign-magnitude divider among NREQ requesters
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N = 32,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic [4:0]        rsp_flags,
  input  logic [NREQ-1:0]   rsp_ack,
  output logic              busy,
  output logic [N-1:0]      div_a,
  output logic [N-1:0]      div_b,
  input  logic [N-1:0]      div_c,
  input  logic              div_cout,
  input  logic              div_zero,
  input  logic              div_overflow,
  input  logic              div_neg
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, owner, win_idx;
  logic [NREQ-1:0] grant;
  logic [CW-1:0] cnt;
  logic [N-1:0] a_r, b_r, a_in, b_in, res_data;
  logic [FLG_W-1:0] res_flags;
  logic hs, b_zero, sgn;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(win_idx)
  );
  assign a_in = req_a[int'(win_idx)*N +: N];
  assign b_in = req_b[int'(win_idx)*N +: N];
  assign hs = state == IDLE && |(req_valid & grant);
  assign b_zero = b_in[MAG_W-1:0] == '0;
  assign sgn = a_in[SIGN_BIT] ^ b_in[SIGN_BIT];
  assign req_ready = state == IDLE ? grant : '0;
  assign rsp_valid = state == RESP ? NREQ'(1) << owner : '0;
  assign rsp_data = state == RESP ? res_data : '0;
  assign rsp_flags = state == RESP ? res_flags : '0;
  assign busy = state != IDLE;
  assign div_a = state == BUSY ? a_r : '0;
  assign div_b = state == BUSY ? b_r : '0;
  always_comb begin
    state_n = state;
    if (hs) state_n = b_zero ? RESP : BUSY;
    if (state == BUSY && cnt == '0) state_n = RESP;
    if (state == RESP && rsp_ack[owner]) state_n = IDLE;
  end
  // The saturated divide-by-zero result is loaded on every accept; a real divide overwrites it at capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= IW'(NREQ - 1);
      owner <= '0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      res_data <= '0;
      res_flags <= '0;
    end else begin
      state <= state_n;
      if (hs) begin
        a_r <= a_in;
        b_r <= b_in;
        owner <= win_idx;
        rr_ptr <= win_idx;
        cnt <= CW'(DIV_CYCLES - 1);
        res_data <= N'({sgn, DBZ_MAG});
        res_flags <= {1'b1, 1'b1, sgn, a_in[MAG_W-1:0] == '0, 1'b0};
      end
      if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          res_data <= div_c;
          res_flags <= {1'b0, div_overflow, div_neg, div_zero, div_cout};
        end
      end
    end
  end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: vector table, corner sequences and randomized ops against a reference model
module tb_div_share_ctrl;
  import div_ctrl_pkg::*;
  localparam int NREQ = 4;
  localparam int N = 32;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] rsp_ack = '0;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [N-1:0] rsp_data, div_a, div_b, div_c;
  logic [4:0] rsp_flags;
  logic busy, div_cout, div_zero, div_overflow, div_neg;
  int tests = 0;
  int fails = 0;
  int rr = NREQ - 1;
  always #5 clk = ~clk;
  div_share_ctrl #(.NREQ(NREQ), .N(N), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_ack(rsp_ack), .busy(busy), .div_a(div_a), .div_b(div_b), .div_c(div_c),
    .div_cout(div_cout), .div_zero(div_zero), .div_overflow(div_overflow), .div_neg(div_neg)
  );
  // Stand-in Q7.8 sign-magnitude divider: {ovf, neg, zero, cout, result}
  function automatic logic [35:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic s, o;
    s = a[15] ^ b[15];
    q = (b[14:0] == 15'h0) ? 32'h0 : ({17'b0, a[14:0]} << 8) / {17'b0, b[14:0]};
    o = q > 32'h7FFF;
    return {o, s, q == 32'h0, 1'b0, 16'b0, s, o ? 15'h7FFF : q[14:0]};
  endfunction
  always_comb {div_overflow, div_neg, div_zero, div_cout, div_c} = div_ref(div_a, div_b);
  // Expected response {flags, data}: divide-by-zero is answered without the divider
  function automatic logic [36:0] expect_rsp(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] d;
    logic s;
    s = a[15] ^ b[15];
    if (b[14:0] == 15'h0) return {1'b1, 1'b1, s, a[14:0] == 15'h0, 1'b0, 16'b0, s, 15'h7FFF};
    d = div_ref(a, b);
    return {1'b0, d[35:32], d[31:0]};
  endfunction
  function automatic int winner(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (((m >> ((rr + k) % NREQ)) & NREQ'(1)) != '0) return (rr + k) % NREQ;
    return 0;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Starts and ends at the drive point, 1 time unit after a rising edge
  task automatic run_op(input logic [NREQ-1:0] m, input int w, input logic [31:0] ed,
                        input logic [4:0] ef, input int elat, input int ack_dly);
    int lat;
    bit div_ok;
    logic [31:0] ea, eb;
    ea = req_a[w*N +: N];
    eb = req_b[w*N +: N];
    req_valid = m;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(NREQ'(1) << w));
    @(posedge clk); #1;
    req_valid = '0;
    rr = w;
    lat = 1;
    div_ok = 1'b1;
    while (rsp_valid == '0 && lat < 30) begin
      if (div_a !== ea || div_b !== eb || !busy) div_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("div_hold", 64'(div_ok), 64'(1));
    chk("latency", 64'(lat), 64'(elat));
    chk("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << w));
    chk("rsp_data", 64'(rsp_data), 64'(ed));
    chk("rsp_flags", 64'(rsp_flags), 64'(ef));
    chk("div_idle", 64'({div_a, div_b}), 64'(0));
    for (int i = 0; i < ack_dly; i++) begin
      rsp_ack = NREQ'(1) << ((w + 1 + i % (NREQ - 1)) % NREQ);
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'(NREQ'(1) << w));
      chk("hold_rsp", 64'({rsp_flags, rsp_data}), 64'({ef, ed}));
    end
    rsp_ack = NREQ'(1) << w;
    @(posedge clk); #1;
    rsp_ack = '0;
    chk("idle_after_ack", 64'({busy, rsp_valid}), 64'(0));
  endtask
  typedef struct {
    int w;
    logic [31:0] a, b, d;
    logic [4:0] f;
    int lat, dly;
  } vec_t;
  vec_t tv[7];
  logic [NREQ-1:0] gready[5];
  int gcyc[5];
  int ng;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0] = '{0, 32'h0600, 32'h0200, 32'h0300, 5'b00000, DC + 1, 0};
    tv[1] = '{2, 32'h0180, 32'h0080, 32'h0300, 5'b00000, DC + 1, 0};
    tv[2] = '{2, 32'h8600, 32'h0200, 32'h8300, 5'(1 << FLG_NEG), DC + 1, 1};
    tv[3] = '{1, 32'h0100, 32'h8000, 32'h0000FFFF, 5'b11100, 1, 2};
    tv[4] = '{0, 32'h0600, 32'h0200, 32'h0300, 5'b00000, DC + 1, 10};
    tv[5] = '{3, 32'h0000, 32'h0000, 32'h00007FFF, 5'b11010, 1, 0};
    tv[6] = '{1, 32'h7F00, 32'h0080, 32'h00007FFF, 5'(1 << FLG_OVF), DC + 1, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_flags, busy}), 64'(0));
    chk("reset_div", 64'({div_a, div_b}), 64'(0));
    rst_n = 1'b1;
    for (int t = 0; t < 7; t++) begin
      req_a = '0;
      req_b = '0;
      req_a[tv[t].w*N +: N] = tv[t].a;
      req_b[tv[t].w*N +: N] = tv[t].b;
      run_op(NREQ'(1) << tv[t].w, tv[t].w, tv[t].d, tv[t].f, tv[t].lat, tv[t].dly);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'h0600;
      req_b[i*N +: N] = 32'h0200;
    end
    req_valid = '1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gready[ng] = req_ready;
        gcyc[ng] = c;
        ng++;
      end
      @(posedge clk); #1;
      rsp_ack = rsp_valid;
    end
    req_valid = '0;
    for (int c = 0; c < 20 && rsp_valid == '0; c++) begin
      @(posedge clk); #1;
    end
    rsp_ack = rsp_valid;
    @(posedge clk); #1;
    rsp_ack = '0;
    chk("rr_grants", 64'(ng), 64'(5));
    for (int k = 0; k < ng; k++) begin
      chk("rr_order", 64'(gready[k]), 64'(NREQ'(1) << (k % NREQ)));
      chk("rr_spacing", 64'(gcyc[k]), 64'(k * (DC + 2)));
    end
    chk("rr_drained", 64'(busy), 64'(0));
    req_a = '0;
    req_b = '0;
    req_a[0 +: N] = 32'h0600;
    req_b[0 +: N] = 32'h0200;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("busy_before_reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_flags, busy}), 64'(0));
    chk("mid_reset_div", 64'({div_a, div_b}), 64'(0));
    rst_n = 1'b1;
    rr = NREQ - 1;
    req_a[3*N +: N] = 32'h0180;
    req_b[3*N +: N] = 32'h0080;
    begin
      logic [36:0] e;
      e = expect_rsp(req_a[0 +: N], req_b[0 +: N]);
      run_op(4'b1001, winner(4'b1001), e[31:0], e[36:32], DC + 1, 0);
    end
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] m;
      logic [36:0] e;
      int w;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*N +: N] = {16'b0, 16'($urandom)};
        req_b[i*N +: N] = {16'b0, ($urandom_range(0, 3) == 0) ? {1'($urandom), 15'h0} : 16'($urandom)};
      end
      w = winner(m);
      e = expect_rsp(req_a[w*N +: N], req_b[w*N +: N]);
      run_op(m, w, e[31:0], e[36:32], e[36] ? 1 : DC + 1, int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
